rename_map_table: RTL and testbench

//  Speculative register alias table for the rename stage, directly upstream of the ROB.

---
 rtl/rename_map_table.sv | 117 +++++++++++
 tb/tb_rename_map_table.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rename_map_table.sv
`default_nettype none
// ============================================================================
// rename_map_table : speculative register alias table for the rename stage.
// Maps each architectural register to the ROB pointer of its youngest producer.
// Revision: 1.0 - initial release
// ============================================================================
module rename_map_table #(
  parameter int AREG_NUM     = 32,
  parameter int FETCH_WIDTH  = 2,
  parameter int COMMIT_WIDTH = 2,
  parameter int PTR_W        = 6
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [FETCH_WIDTH-1:0]              ren_valid,
  input  logic [FETCH_WIDTH-1:0][4:0]         ren_src1,
  input  logic [FETCH_WIDTH-1:0][4:0]         ren_src2,
  input  logic [FETCH_WIDTH-1:0][4:0]         ren_dst,
  input  logic [FETCH_WIDTH-1:0][PTR_W-1:0]   ren_ptr,
  input  logic                                ren_stall,
  output logic [FETCH_WIDTH-1:0]              src1_busy,
  output logic [FETCH_WIDTH-1:0][PTR_W-1:0]   src1_ptr,
  output logic [FETCH_WIDTH-1:0]              src2_busy,
  output logic [FETCH_WIDTH-1:0][PTR_W-1:0]   src2_ptr,
  input  logic [COMMIT_WIDTH-1:0]             ret_valid,
  input  logic [COMMIT_WIDTH-1:0][4:0]        ret_dst,
  input  logic [COMMIT_WIDTH-1:0][PTR_W-1:0]  ret_ptr,
  input  logic                                flush
);

  logic [AREG_NUM-1:0]             r_busy;
  logic [AREG_NUM-1:0][PTR_W-1:0]  r_ptr;
  logic [AREG_NUM-1:0]             w_busy_nxt;
  logic [AREG_NUM-1:0][PTR_W-1:0]  w_ptr_nxt;
  logic [PTR_W:0]                  w_look1;
  logic [PTR_W:0]                  w_look2;

  // Returns {busy, ptr}; older lanes in the same group override the table,
  // with the youngest older lane winning.
  function automatic logic [PTR_W:0] f_lookup(
    input int                               lane,
    input logic [4:0]                       src,
    input logic [FETCH_WIDTH-1:0]           vld,
    input logic [FETCH_WIDTH-1:0][4:0]      dst,
    input logic [FETCH_WIDTH-1:0][PTR_W-1:0] ptr,
    input logic [AREG_NUM-1:0]              tbusy,
    input logic [AREG_NUM-1:0][PTR_W-1:0]   tptr
  );
    logic [PTR_W:0] res;
    res = tbusy[src] ? {1'b1, tptr[src]} : '0;
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      if (j < lane && vld[j] && dst[j] == src) begin
        res = {1'b1, ptr[j]};
      end
    end
    if (src == 5'd0) begin
      res = '0;
    end
    return res;
  endfunction

  always_comb begin
    src1_busy = '0;
    src1_ptr  = '0;
    src2_busy = '0;
    src2_ptr  = '0;
    w_look1   = '0;
    w_look2   = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_look1 = f_lookup(i, ren_src1[i], ren_valid, ren_dst, ren_ptr, r_busy, r_ptr);
      w_look2 = f_lookup(i, ren_src2[i], ren_valid, ren_dst, ren_ptr, r_busy, r_ptr);
      // Outputs follow the asynchronous reset immediately, bypass included.
      if (reset) begin
        src1_busy[i] = w_look1[PTR_W];
        src1_ptr[i]  = w_look1[PTR_W-1:0];
        src2_busy[i] = w_look2[PTR_W];
        src2_ptr[i]  = w_look2[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    w_busy_nxt = r_busy;
    w_ptr_nxt  = r_ptr;
    if (flush) begin
      w_busy_nxt = '0;
    end else begin
      // Retire compares against the pre-update entry, so stale retires are no-ops.
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (ret_valid[k] && ret_dst[k] != 5'd0 &&
            r_busy[ret_dst[k]] && r_ptr[ret_dst[k]] == ret_ptr[k]) begin
          w_busy_nxt[ret_dst[k]] = 1'b0;
        end
      end
      if (!ren_stall) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
          if (ren_valid[i] && ren_dst[i] != 5'd0) begin
            w_busy_nxt[ren_dst[i]] = 1'b1;
            w_ptr_nxt[ren_dst[i]]  = ren_ptr[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
      r_ptr  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_ptr  <= w_ptr_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rename_map_table.sv
`default_nettype none
// Testbench for rename_map_table: directed vector table, reset corner case,
// then randomized traffic checked against a behavioural alias-table model.
module tb_rename_map_table;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]            ren_valid;
  logic [1:0][4:0]       ren_src1, ren_src2, ren_dst;
  logic [1:0][5:0]       ren_ptr;
  logic                  ren_stall;
  logic [1:0]            src1_busy, src2_busy;
  logic [1:0][5:0]       src1_ptr, src2_ptr;
  logic [1:0]            ret_valid;
  logic [1:0][4:0]       ret_dst;
  logic [1:0][5:0]       ret_ptr;
  logic                  flush;

  rename_map_table #(.AREG_NUM(32), .FETCH_WIDTH(2), .COMMIT_WIDTH(2), .PTR_W(6)) dut (
    .clk(clk), .reset(reset),
    .ren_valid(ren_valid), .ren_src1(ren_src1), .ren_src2(ren_src2),
    .ren_dst(ren_dst), .ren_ptr(ren_ptr), .ren_stall(ren_stall),
    .src1_busy(src1_busy), .src1_ptr(src1_ptr),
    .src2_busy(src2_busy), .src2_ptr(src2_ptr),
    .ret_valid(ret_valid), .ret_dst(ret_dst), .ret_ptr(ret_ptr),
    .flush(flush)
  );

  typedef struct {
    logic [1:0]      rv;
    logic [1:0][4:0] s1, s2, d;
    logic [1:0][5:0] p;
    logic            st;
    logic [1:0]      tv;
    logic [1:0][4:0] td;
    logic [1:0][5:0] tp;
    logic            fl;
    logic [1:0]      e1b;
    logic [1:0][5:0] e1p;
    logic [1:0]      e2b;
    logic [1:0][5:0] e2p;
  } vec_t;

  typedef struct packed {
    logic [1:0]      b1;
    logic [1:0][5:0] p1;
    logic [1:0]      b2;
    logic [1:0][5:0] p2;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic       m_busy [32];
  logic [5:0] m_ptr  [32];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, req);
  endtask

  task automatic drive(input vec_t v);
    ren_valid = v.rv; ren_src1 = v.s1; ren_src2 = v.s2; ren_dst = v.d;
    ren_ptr = v.p; ren_stall = v.st; ret_valid = v.tv; ret_dst = v.td;
    ret_ptr = v.tp; flush = v.fl;
  endtask

  task automatic sample(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      n_chk++;
      $display("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
    end else begin
      e = q.pop_front();
      chk({tag, ".src1_busy"}, {14'd0, src1_busy}, {14'd0, e.b1});
      chk({tag, ".src1_ptr"},  {4'd0, src1_ptr},   {4'd0, e.p1});
      chk({tag, ".src2_busy"}, {14'd0, src2_busy}, {14'd0, e.b2});
      chk({tag, ".src2_ptr"},  {4'd0, src2_ptr},   {4'd0, e.p2});
    end
  endtask

  function automatic logic [6:0] mlook(input int lane, input logic [4:0] s);
    logic [6:0] r;
    r = m_busy[s] ? {1'b1, m_ptr[s]} : 7'd0;
    for (int j = 0; j < lane; j++)
      if (ren_valid[j] && ren_dst[j] == s) r = {1'b1, ren_ptr[j]};
    if (s == 5'd0) r = 7'd0;
    return r;
  endfunction

  task automatic model_update();
    logic       nb [32];
    logic [5:0] np [32];
    for (int r = 0; r < 32; r++) begin nb[r] = m_busy[r]; np[r] = m_ptr[r]; end
    if (flush) begin
      for (int r = 0; r < 32; r++) nb[r] = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++)
        if (ret_valid[k] && ret_dst[k] != 0 && m_busy[ret_dst[k]] && m_ptr[ret_dst[k]] == ret_ptr[k])
          nb[ret_dst[k]] = 1'b0;
      if (!ren_stall)
        for (int i = 0; i < 2; i++)
          if (ren_valid[i] && ren_dst[i] != 0) begin nb[ren_dst[i]] = 1'b1; np[ren_dst[i]] = ren_ptr[i]; end
    end
    for (int r = 0; r < 32; r++) begin m_busy[r] = nb[r]; m_ptr[r] = np[r]; end
  endtask

  vec_t vt[14];
  vec_t v;
  exp_t e;
  logic [6:0] l10, l11, l20, l21;

  initial begin
    // Columns: rv, s1, s2, d, p, stall, ret_valid, ret_dst, ret_ptr, flush | expected.
    vt[0]  = '{2'b00, {5'd0,5'd5}, {5'd0,5'd0}, '0, '0, 1'b0, 2'b00, '0, '0, 1'b0,
               2'b00, '0, 2'b00, '0};
    vt[1]  = '{2'b01, {5'd3,5'd0}, {5'd0,5'd3}, {5'd0,5'd3}, {6'h00,6'h04}, 1'b0, 2'b00, '0, '0, 1'b0,
               2'b10, {6'h04,6'h00}, 2'b00, '0};
    vt[2]  = '{2'b11, {5'd0,5'd3}, {5'd3,5'd0}, {5'd7,5'd7}, {6'h11,6'h10}, 1'b0, 2'b00, '0, '0, 1'b0,
               2'b01, {6'h00,6'h04}, 2'b10, {6'h04,6'h00}};
    vt[3]  = '{2'b01, {5'd7,5'd7}, {5'd9,5'd0}, {5'd0,5'd9}, {6'h00,6'h21}, 1'b0, 2'b01, {5'd0,5'd7}, {6'h00,6'h10}, 1'b0,
               2'b11, {6'h11,6'h11}, 2'b10, {6'h21,6'h00}};
    vt[4]  = '{2'b00, {5'd7,5'd9}, {5'd0,5'd0}, '0, '0, 1'b0, 2'b11, {5'd9,5'd7}, {6'h01,6'h11}, 1'b0,
               2'b11, {6'h11,6'h21}, 2'b00, '0};
    vt[5]  = '{2'b01, {5'd9,5'd7}, {5'd0,5'd0}, {5'd0,5'd4}, {6'h00,6'h02}, 1'b0, 2'b10, {5'd9,5'd0}, {6'h21,6'h00}, 1'b0,
               2'b10, {6'h21,6'h00}, 2'b00, '0};
    vt[6]  = '{2'b10, {5'd4,5'd9}, {5'd0,5'd0}, {5'd4,5'd0}, {6'h08,6'h00}, 1'b0, 2'b01, {5'd0,5'd4}, {6'h00,6'h02}, 1'b0,
               2'b10, {6'h02,6'h00}, 2'b00, '0};
    vt[7]  = '{2'b01, {5'd0,5'd4}, {5'd6,5'd0}, {5'd0,5'd6}, {6'h00,6'h0A}, 1'b1, 2'b00, '0, '0, 1'b0,
               2'b01, {6'h00,6'h08}, 2'b10, {6'h0A,6'h00}};
    vt[8]  = '{2'b01, {5'd6,5'd0}, {5'd0,5'd4}, {5'd0,5'd2}, {6'h00,6'h0C}, 1'b0, 2'b01, {5'd0,5'd4}, {6'h00,6'h08}, 1'b1,
               2'b00, '0, 2'b01, {6'h00,6'h08}};
    vt[9]  = '{2'b00, {5'd2,5'd4}, {5'd7,5'd3}, '0, '0, 1'b0, 2'b00, '0, '0, 1'b0,
               2'b00, '0, 2'b00, '0};
    vt[10] = '{2'b11, {5'd0,5'd0}, {5'd0,5'd0}, {5'd0,5'd0}, {6'h06,6'h05}, 1'b0, 2'b00, '0, '0, 1'b0,
               2'b00, '0, 2'b00, '0};
    vt[11] = '{2'b11, {5'd5,5'd0}, {5'd0,5'd0}, {5'd5,5'd5}, {6'h15,6'h14}, 1'b0, 2'b00, '0, '0, 1'b0,
               2'b10, {6'h14,6'h00}, 2'b00, '0};
    vt[12] = '{2'b00, {5'd5,5'd0}, {5'd0,5'd5}, '0, '0, 1'b0, 2'b11, {5'd5,5'd5}, {6'h15,6'h15}, 1'b0,
               2'b10, {6'h15,6'h00}, 2'b01, {6'h00,6'h15}};
    vt[13] = '{2'b00, {5'd5,5'd5}, {5'd0,5'd0}, '0, '0, 1'b0, 2'b01, {5'd0,5'd0}, {6'h00,6'h00}, 1'b0,
               2'b00, '0, 2'b00, '0};

    reset = 1'b0;
    v = '{2'b01, {5'd3,5'd5}, {5'd3,5'd5}, {5'd0,5'd3}, {6'h00,6'h04}, 1'b0, 2'b00, '0, '0, 1'b0,
          2'b00, '0, 2'b00, '0};
    drive(v);
    #1;
    q.push_back('0);
    sample("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(vt[i]);
      q.push_back({vt[i].e1b, vt[i].e1p, vt[i].e2b, vt[i].e2p});
      @(negedge clk);
      sample($sformatf("vec%0d", i));
      @(posedge clk); #1;
    end

    // Asynchronous reset while a group is being presented.
    v = '{2'b01, '0, '0, {5'd0,5'd10}, {6'h00,6'h1A}, 1'b0, 2'b00, '0, '0, 1'b0, 2'b00, '0, 2'b00, '0};
    drive(v);
    @(posedge clk); #1;
    v = '{2'b01, {5'd10,5'd0}, {5'd0,5'd10}, {5'd0,5'd10}, {6'h00,6'h1B}, 1'b0, 2'b00, '0, '0, 1'b0, 2'b00, '0, 2'b00, '0};
    drive(v);
    #2;
    q.push_back({2'b10, {6'h1B,6'h00}, 2'b01, {6'h00,6'h1A}});
    sample("prerst");
    #1 reset = 1'b0;
    #1;
    q.push_back('0);
    sample("midrst");
    ren_valid = 2'b00;
    #1 reset = 1'b1;
    #1;
    q.push_back('0);
    sample("postrst");
    @(posedge clk); #1;

    for (int r = 0; r < 32; r++) begin m_busy[r] = 1'b0; m_ptr[r] = 6'd0; end
    for (int c = 0; c < 300; c++) begin
      ren_valid = 2'($urandom);
      ren_stall = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      ret_valid = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        ren_src1[i] = 5'($urandom_range(0, 7));
        ren_src2[i] = 5'($urandom_range(0, 7));
        ren_dst[i]  = 5'($urandom_range(0, 7));
        ren_ptr[i]  = 6'($urandom);
        ret_dst[i]  = 5'($urandom_range(0, 7));
        ret_ptr[i]  = ($urandom_range(0, 1) == 1) ? m_ptr[ret_dst[i]] : 6'($urandom);
      end
      l10 = mlook(0, ren_src1[0]); l11 = mlook(1, ren_src1[1]);
      l20 = mlook(0, ren_src2[0]); l21 = mlook(1, ren_src2[1]);
      e = {l11[6], l10[6], l11[5:0], l10[5:0], l21[6], l20[6], l21[5:0], l20[5:0]};
      q.push_back(e);
      @(negedge clk);
      sample($sformatf("rnd%0d", c));
      model_update();
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
